// File: rtl/multi_channel_accumulator.sv
// Multi-channel session accumulator: sums strobed operands inside a load window and
// commits the result and merged attributes to one of CHANNELS result registers.
module multi_channel_accumulator #(
    parameter int DATA_WIDTH = 8,
    parameter int ATTR_WIDTH = 4,
    parameter int SIGN       = 0,
    parameter int OVERFLOW   = 1,
    parameter int CHANNELS   = 4,
    parameter int MAX_OPS    = 15,
    localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int OPC_W     = $clog2(MAX_OPS + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  signal_load,
    input  logic                  signal_init,
    input  logic                  signal_neg,
    input  logic                  signal_oe,
    input  logic [CH_W-1:0]       chan_sel,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ATTR_WIDTH-1:0] attr_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [ATTR_WIDTH-1:0] attr_out,
    output logic                  result_valid,
    output logic                  overflow,
    output logic [OPC_W-1:0]      op_count,
    output logic                  busy
);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_ACCUM, S_DONE} state_t;

    localparam logic [DATA_WIDTH-1:0] MAX_U = '1;
    localparam logic [DATA_WIDTH-1:0] MAX_S = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] MIN_S = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    state_t                r_state;
    state_t                w_nextState;
    logic [DATA_WIDTH-1:0] r_acc;
    logic [ATTR_WIDTH-1:0] r_attr;
    logic [OPC_W-1:0]      r_opCount;
    logic                  r_overflow;
    logic                  r_used;
    logic [CH_W-1:0]       r_chan;
    logic [DATA_WIDTH-1:0] r_chanReg  [CHANNELS];
    logic [ATTR_WIDTH-1:0] r_chanAttr [CHANNELS];
    logic [DATA_WIDTH-1:0] r_dataOut;
    logic [ATTR_WIDTH-1:0] r_attrOut;

    logic                  w_active;
    logic                  w_attempt;
    logic                  w_capture;
    logic                  w_excess;
    logic [DATA_WIDTH-1:0] w_baseVal;
    logic [DATA_WIDTH:0]   w_base;
    logic [DATA_WIDTH:0]   w_opnd;
    logic [DATA_WIDTH:0]   w_sum;
    logic                  w_oor;
    logic [DATA_WIDTH-1:0] w_limit;
    logic [DATA_WIDTH-1:0] w_result;

    assign w_active  = (r_state == S_ARMED) || (r_state == S_ACCUM);
    assign w_attempt = signal_load & signal_init & ~r_used & w_active;
    assign w_capture = w_attempt & (r_opCount < OPC_W'(MAX_OPS));
    assign w_excess  = w_attempt & ~w_capture;

    // The first operand of a session starts from zero, so ARMED gets the same range check as ACCUM.
    always_comb begin
        w_baseVal = (r_state == S_ARMED) ? '0 : r_acc;
        if (SIGN != 0) begin
            w_base = {w_baseVal[DATA_WIDTH-1], w_baseVal};
            w_opnd = {data_in[DATA_WIDTH-1], data_in};
        end else begin
            w_base = {1'b0, w_baseVal};
            w_opnd = {1'b0, data_in};
        end
        w_sum = signal_neg ? (w_base - w_opnd) : (w_base + w_opnd);
        if (SIGN != 0) begin
            w_oor   = w_sum[DATA_WIDTH] ^ w_sum[DATA_WIDTH-1];
            w_limit = w_sum[DATA_WIDTH] ? MIN_S : MAX_S;
        end else begin
            w_oor   = w_sum[DATA_WIDTH];
            w_limit = signal_neg ? '0 : MAX_U;
        end
        w_result = (w_oor && (OVERFLOW != 0)) ? w_limit : w_sum[DATA_WIDTH-1:0];
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:  if (signal_load) w_nextState = S_ARMED;
            S_ARMED: begin
                if (!signal_load)   w_nextState = S_IDLE;
                else if (w_capture) w_nextState = S_ACCUM;
            end
            S_ACCUM: if (!signal_load) w_nextState = S_DONE;
            S_DONE:  w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_acc      <= '0;
            r_attr     <= '0;
            r_opCount  <= '0;
            r_overflow <= 1'b0;
            r_used     <= 1'b0;
            r_chan     <= '0;
            r_dataOut  <= '0;
            r_attrOut  <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_chanReg[i]  <= '0;
                r_chanAttr[i] <= '0;
            end
        end else begin
            r_state <= w_nextState;
            r_used  <= signal_init ? (r_used | w_attempt) : 1'b0;
            if ((r_state == S_IDLE) && signal_load) begin
                r_chan     <= chan_sel;
                r_acc      <= '0;
                r_attr     <= '0;
                r_opCount  <= '0;
                r_overflow <= 1'b0;
            end
            if (w_capture) begin
                r_acc     <= w_result;
                r_attr    <= r_attr | attr_in;
                r_opCount <= r_opCount + OPC_W'(1);
                if (w_oor) r_overflow <= 1'b1;
            end
            if (w_excess) r_overflow <= 1'b1;
            if ((r_state == S_DONE) && (int'(r_chan) < CHANNELS)) begin
                r_chanReg[r_chan]  <= r_acc;
                r_chanAttr[r_chan] <= r_attr;
            end
            // Readback samples the register file before this edge's commit, hence two cycles after DONE.
            if (signal_oe && (int'(chan_sel) < CHANNELS)) begin
                r_dataOut <= r_chanReg[chan_sel];
                r_attrOut <= r_chanAttr[chan_sel];
            end else begin
                r_dataOut <= '0;
                r_attrOut <= '0;
            end
        end
    end

    assign data_out     = r_dataOut;
    assign attr_out     = r_attrOut;
    assign result_valid = (r_state == S_DONE);
    assign overflow     = r_overflow;
    assign op_count     = r_opCount;
    assign busy         = w_active;

endmodule

// File: tb/tb_multi_channel_accumulator.sv
// Bench for multi_channel_accumulator: three configurations (unsigned saturate, unsigned wrap,
// signed saturate) share one stimulus stream and are checked against an integer reference model.
module tb_multi_channel_accumulator;

    logic       clk = 1'b0;
    logic       rst_n, load, init, neg, oe;
    logic [1:0] chanSel;
    logic [7:0] dataIn;
    logic [3:0] attrIn;

    logic [2:0][7:0] dOut;
    logic [2:0][3:0] aOut;
    logic [2:0][3:0] cnt;
    logic [2:0]      rv, ovf, bsy;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: index 0 unsigned/saturate, 1 unsigned/wrap, 2 signed/saturate.
    int         mAcc [3];
    bit         mOvf [3];
    int         mCnt;
    logic [3:0] mAttr;
    int         mCh;
    logic [7:0] mChan [3][4];
    logic [3:0] mChA  [4];

    always #5 clk = ~clk;

    multi_channel_accumulator #(.SIGN(0), .OVERFLOW(1)) dutUS (
        .clk(clk), .rst_n(rst_n), .signal_load(load), .signal_init(init), .signal_neg(neg),
        .signal_oe(oe), .chan_sel(chanSel), .data_in(dataIn), .attr_in(attrIn),
        .data_out(dOut[0]), .attr_out(aOut[0]), .result_valid(rv[0]), .overflow(ovf[0]),
        .op_count(cnt[0]), .busy(bsy[0]));

    multi_channel_accumulator #(.SIGN(0), .OVERFLOW(0)) dutUW (
        .clk(clk), .rst_n(rst_n), .signal_load(load), .signal_init(init), .signal_neg(neg),
        .signal_oe(oe), .chan_sel(chanSel), .data_in(dataIn), .attr_in(attrIn),
        .data_out(dOut[1]), .attr_out(aOut[1]), .result_valid(rv[1]), .overflow(ovf[1]),
        .op_count(cnt[1]), .busy(bsy[1]));

    multi_channel_accumulator #(.SIGN(1), .OVERFLOW(1)) dutSS (
        .clk(clk), .rst_n(rst_n), .signal_load(load), .signal_init(init), .signal_neg(neg),
        .signal_oe(oe), .chan_sel(chanSel), .data_in(dataIn), .attr_in(attrIn),
        .data_out(dOut[2]), .attr_out(aOut[2]), .result_valid(rv[2]), .overflow(ovf[2]),
        .op_count(cnt[2]), .busy(bsy[2]));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic l, input logic i, input logic n, input logic [7:0] d, input logic [3:0] a);
        load   = l;
        init   = i;
        neg    = n;
        dataIn = d;
        attrIn = a;
    endtask

    task automatic modelStep(input int acc, input int d, input bit n, input bit sgn, input bit sat,
                             output int res, output bit oor);
        int dv, lo, hi, v;
        if (sgn) begin
            dv = (d >= 128) ? d - 256 : d;
            lo = -128;
            hi = 127;
        end else begin
            dv = d;
            lo = 0;
            hi = 255;
        end
        v   = n ? acc - dv : acc + dv;
        oor = (v < lo) || (v > hi);
        if (!oor)     res = v;
        else if (sat) res = (v < lo) ? lo : hi;
        else begin
            res = v & 255;
            if (sgn && res >= 128) res -= 256;
        end
    endtask

    task automatic modelCapture(input int d, input bit n, input logic [3:0] a);
        int r;
        bit o;
        if (mCnt < 15) begin
            for (int k = 0; k < 3; k++) begin
                modelStep(mAcc[k], d, n, (k == 2), (k != 1), r, o);
                mAcc[k] = r;
                if (o) mOvf[k] = 1'b1;
            end
            mAttr = mAttr | a;
            mCnt++;
        end else begin
            for (int k = 0; k < 3; k++) mOvf[k] = 1'b1;
        end
    endtask

    task automatic startSession(input int ch, input string tag);
        chanSel = 2'(ch);
        load    = 1'b1;
        for (int k = 0; k < 3; k++) begin
            mAcc[k] = 0;
            mOvf[k] = 1'b0;
        end
        mCnt  = 0;
        mAttr = '0;
        mCh   = ch;
        tick();
        checkOutput({tag, "_busy"}, 32'(bsy), 32'h7);
    endtask

    task automatic pulseOp(input int d, input bit n, input logic [3:0] a, input string tag);
        applyStimulus(1'b1, 1'b1, n, 8'(d), a);
        tick();
        modelCapture(d, n, a);
        for (int k = 0; k < 3; k++)
            checkOutput($sformatf("%s_opcnt%0d", tag, k), 32'(cnt[k]), 32'(mCnt));
        init = 1'b0;
        tick();
    endtask

    task automatic readback(input int ch, input string tag);
        chanSel = 2'(ch);
        oe      = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("%s_dout%0d_ch%0d", tag, k, ch), 32'(dOut[k]), 32'(mChan[k][ch]));
            checkOutput($sformatf("%s_aout%0d_ch%0d", tag, k, ch), 32'(aOut[k]), 32'(mChA[ch]));
        end
        oe = 1'b0;
    endtask

    task automatic endSession(input string tag);
        load = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("%s_valid%0d", tag, k), 32'(rv[k]), 32'd1);
            checkOutput($sformatf("%s_ovf%0d", tag, k), 32'(ovf[k]), 32'(mOvf[k]));
            checkOutput($sformatf("%s_cnt%0d", tag, k), 32'(cnt[k]), 32'(mCnt));
            mChan[k][mCh] = 8'(mAcc[k] & 255);
        end
        mChA[mCh] = mAttr;
        tick();
        checkOutput({tag, "_valid_drop"}, 32'(rv), 32'h0);
        checkOutput({tag, "_idle"}, 32'(bsy), 32'h0);
        readback(mCh, tag);
    endtask

    task automatic clearModelChannels;
        for (int c = 0; c < 4; c++) begin
            mChA[c] = '0;
            for (int k = 0; k < 3; k++) mChan[k][c] = '0;
        end
    endtask

    initial begin
        int nOps;
        rst_n   = 1'b0;
        oe      = 1'b1;
        chanSel = '0;
        applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 4'd0);
        clearModelChannels();
        mCnt = 0;
        tick();
        tick();
        rst_n = 1'b1;
        checkOutput("rst_busy", 32'(bsy), 32'h0);
        checkOutput("rst_valid", 32'(rv), 32'h0);
        checkOutput("rst_ovf", 32'(ovf), 32'h0);
        checkOutput("rst_cnt", 32'(cnt), 32'h0);
        checkOutput("rst_dout", 32'(dOut), 32'h0);
        oe = 1'b0;

        $display("[TB] basic sum 5+3 on ch0");
        startSession(0, "sum");
        pulseOp(5, 0, 4'h1, "sum");
        pulseOp(3, 0, 4'h2, "sum");
        endSession("sum");

        $display("[TB] subtraction and sign handling");
        startSession(0, "sub1");
        pulseOp(7, 0, 4'h0, "sub1");
        pulseOp(5, 1, 4'h0, "sub1");
        endSession("sub1");
        startSession(0, "sub2");
        pulseOp(251, 0, 4'h0, "sub2");
        pulseOp(7, 0, 4'h0, "sub2");
        endSession("sub2");
        startSession(0, "sub3");
        pulseOp(3, 0, 4'h0, "sub3");
        pulseOp(5, 1, 4'h0, "sub3");
        endSession("sub3");

        $display("[TB] init raised before load");
        applyStimulus(1'b0, 1'b1, 1'b0, 8'd5, 4'h4);
        tick();
        startSession(0, "early");
        tick();
        modelCapture(5, 0, 4'h4);
        tick();
        checkOutput("early_once", 32'(cnt[0]), 32'(mCnt));
        init = 1'b0;
        tick();
        pulseOp(7, 0, 4'h0, "early");
        endSession("early");

        $display("[TB] range limits");
        startSession(3, "big");
        pulseOp(200, 0, 4'h0, "big");
        pulseOp(100, 0, 4'h0, "big");
        endSession("big");
        startSession(3, "big2");
        pulseOp(100, 0, 4'h0, "big2");
        pulseOp(100, 0, 4'h0, "big2");
        endSession("big2");

        $display("[TB] channel readback and output enable");
        startSession(1, "ch1");
        pulseOp(9, 0, 4'h1, "ch1");
        endSession("ch1");
        startSession(2, "ch2");
        pulseOp(4, 0, 4'h2, "ch2");
        endSession("ch2");
        readback(1, "rb1");
        tick();
        checkOutput("oe_off_dout", 32'(dOut), 32'h0);
        checkOutput("oe_off_aout", 32'(aOut), 32'h0);

        $display("[TB] empty load window");
        startSession(2, "empty");
        tick();
        checkOutput("empty_novalid_a", 32'(rv), 32'h0);
        load = 1'b0;
        tick();
        checkOutput("empty_novalid_b", 32'(rv), 32'h0);
        checkOutput("empty_idle", 32'(bsy), 32'h0);
        tick();
        checkOutput("empty_novalid_c", 32'(rv), 32'h0);
        readback(2, "empty");

        $display("[TB] reset during a session");
        startSession(3, "abort");
        pulseOp(9, 0, 4'h3, "abort");
        rst_n = 1'b0;
        load  = 1'b0;
        tick();
        rst_n = 1'b1;
        clearModelChannels();
        mCnt = 0;
        checkOutput("abort_busy", 32'(bsy), 32'h0);
        checkOutput("abort_cnt", 32'(cnt), 32'h0);
        tick();
        checkOutput("abort_novalid", 32'(rv), 32'h0);
        for (int c = 0; c < 4; c++) readback(c, "abort");

        $display("[TB] operand limit");
        startSession(1, "limit");
        for (int i = 0; i < 16; i++) pulseOp(1, 0, 4'h8, "limit");
        endSession("limit");

        $display("[TB] randomized sessions");
        for (int s = 0; s < 20; s++) begin
            startSession(int'($urandom_range(0, 3)), "rand");
            nOps = int'($urandom_range(1, 5));
            for (int i = 0; i < nOps; i++) begin
                chanSel = 2'($urandom_range(0, 3));
                pulseOp(int'($urandom_range(0, 255)), bit'($urandom_range(0, 1)),
                        4'($urandom_range(0, 15)), "rand");
            end
            endSession("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
